// File: rtl/enc42_capture.sv
// rtl/enc42_capture.sv - registered 4:2 priority encoder with sync, debounce and valid/ack handshake
// ENC42_ACTIVE_LOW_IN_EN: when defined, d lines are active-low (inverted after the synchroniser).
module enc42_capture #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  input  logic       ack,
  output logic [1:0] code,
  output logic       multi,
  output logic       valid
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  logic [3:0]    s1_q, s2_q;
  logic [3:0]    req;
  state_t        state_q, state_d;
  logic [3:0]    snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    code_q, code_d;
  logic          multi_q, multi_d;
  logic          valid_q, valid_d;

`ifdef ENC42_ACTIVE_LOW_IN_EN
  localparam logic [3:0] SYNC_RST = 4'b1111;
  assign req = ~s2_q;
`else
  localparam logic [3:0] SYNC_RST = 4'b0000;
  assign req = s2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= SYNC_RST;
      s2_q <= SYNC_RST;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    multi_d = multi_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 4'd0) begin
          snap_d  = req;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (req == 4'd0) begin
          state_d = ST_IDLE;
        end else if (req != snap_q) begin
          snap_d = req;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = enc4(snap_q);
          // more than one bit set <=> clearing the lowest set bit leaves something
          multi_d = |(snap_q & (snap_q - 4'd1));
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (ack) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (req != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= 4'd0;
      cnt_q   <= '0;
      code_q  <= 2'd0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
    end
  end

  assign code  = code_q;
  assign multi = multi_q;
  assign valid = valid_q;

endmodule
